// File: rtl/atm_transaction_ctrl.sv
// ATM transaction controller: authenticates a card session, then runs one
// customer operation at a time against a captured account balance. It asks
// for card ejection on exit, on lockout or on inactivity.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   card_in           card present in slot (level)
//   psw_en, wrong_psw authentication results; only sampled while authenticating
//   balance           account balance, captured when the password is accepted
//   op_valid/op_ready operation handshake (op_ready high while ready)
//   op_code, amount   00 inquiry, 01 withdraw, 10 deposit, 11 exit; operand
//   op_done           one-cycle pulse when updated_balance/status are valid
//   updated_balance   result balance, held between op_done pulses
//   status            00 ok, 01 insufficient funds, 10 overflow, 11 locked
//   card_out          one-cycle eject request
module atm_transaction_ctrl #(
  parameter int unsigned balance_width  = 20,
  parameter int unsigned max_tries      = 3,
  parameter int unsigned timeout_cycles = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     psw_en,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic                     op_ready,
  output logic                     op_done,
  output logic [balance_width-1:0] updated_balance,
  output logic [1:0]               status,
  output logic                     card_out
);

  localparam int unsigned TRY_W = $clog2(max_tries + 1);
  localparam int unsigned TMR_W = $clog2(timeout_cycles);

  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_EXIT     = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_LOCK  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_AUTH, S_READY, S_EXEC, S_DONE, S_EJECT, S_REMOVE
  } state_t;

  state_t                   state, state_nxt;
  logic [TRY_W-1:0]         tries, tries_nxt;
  logic [TMR_W-1:0]         timer, timer_nxt;
  logic [balance_width-1:0] bal, bal_nxt;
  logic [1:0]               op_q, op_q_nxt;
  logic [balance_width-1:0] amt_q, amt_nxt;
  logic [balance_width-1:0] upd_nxt;
  logic [1:0]               status_nxt;
  logic                     op_ready_nxt, op_done_nxt, card_out_nxt;

  // Operation datapath, evaluated from the latched operation
  logic [balance_width:0]   sum_c;
  logic [balance_width-1:0] result_c;
  logic [1:0]               res_status_c;

  // Register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      tries           <= '0;
      timer           <= '0;
      bal             <= '0;
      op_q            <= '0;
      amt_q           <= '0;
      updated_balance <= '0;
      status          <= ST_OK;
      op_ready        <= 1'b0;
      op_done         <= 1'b0;
      card_out        <= 1'b0;
    end else begin
      state           <= state_nxt;
      tries           <= tries_nxt;
      timer           <= timer_nxt;
      bal             <= bal_nxt;
      op_q            <= op_q_nxt;
      amt_q           <= amt_nxt;
      updated_balance <= upd_nxt;
      status          <= status_nxt;
      op_ready        <= op_ready_nxt;
      op_done         <= op_done_nxt;
      card_out        <= card_out_nxt;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    timer_nxt    = timer;
    bal_nxt      = bal;
    op_q_nxt     = op_q;
    amt_nxt      = amt_q;
    upd_nxt      = updated_balance;
    status_nxt   = status;
    sum_c        = {1'b0, bal} + {1'b0, amt_q};
    result_c     = bal;
    res_status_c = ST_OK;

    case (op_q)
      OP_WITHDRAW: begin
        if (amt_q > bal) res_status_c = ST_INSUF;
        else             result_c     = bal - amt_q;
      end
      OP_DEPOSIT: begin
        if (sum_c[balance_width]) res_status_c = ST_OVF;
        else                      result_c     = sum_c[balance_width-1:0];
      end
      default: ;
    endcase

    case (state)
      S_IDLE: begin
        tries_nxt = '0;
        timer_nxt = '0;
        if (card_in) state_nxt = S_AUTH;
      end
      S_AUTH: begin
        if (psw_en) begin
          bal_nxt   = balance;
          tries_nxt = '0;
          timer_nxt = '0;
          state_nxt = S_READY;
        end else if (wrong_psw) begin
          tries_nxt = TRY_W'(tries + 1'b1);
          if (tries_nxt == TRY_W'(max_tries)) begin
            status_nxt = ST_LOCK;
            state_nxt  = S_EJECT;
          end
        end else if (!card_in) begin
          state_nxt = S_IDLE;
        end
      end
      S_READY: begin
        if (op_valid) begin
          op_q_nxt  = op_code;
          amt_nxt   = amount;
          timer_nxt = '0;
          state_nxt = S_EXEC;
        end else if (!card_in) begin
          state_nxt = S_IDLE;
        end else if (timer == TMR_W'(timeout_cycles - 1)) begin
          timer_nxt = '0;
          state_nxt = S_EJECT;
        end else begin
          timer_nxt = TMR_W'(timer + 1'b1);
        end
      end
      S_EXEC: begin
        // Result is published and committed as the FSM enters DONE
        upd_nxt    = result_c;
        status_nxt = res_status_c;
        bal_nxt    = result_c;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        timer_nxt = '0;
        if (op_q == OP_EXIT) state_nxt = S_EJECT;
        else if (!card_in)   state_nxt = S_IDLE;
        else                 state_nxt = S_READY;
      end
      S_EJECT:  state_nxt = S_REMOVE;
      S_REMOVE: if (!card_in) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Flags are registered against the state being entered
    op_ready_nxt = (state_nxt == S_READY);
    op_done_nxt  = (state_nxt == S_DONE);
    card_out_nxt = (state_nxt == S_EJECT);
  end

endmodule

// File: tb/tb_atm_transaction_ctrl.sv
// Directed bench for atm_transaction_ctrl. A balance model (plain integer
// arithmetic) predicts updated_balance/status; the scenario code states the
// expected handshake flags for each cycle; a negedge process compares every
// output on every cycle after reset.
module tb_atm_transaction_ctrl;

  localparam int unsigned BW      = 20;
  localparam longint      BAL_MAX = (longint'(1) << BW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          card_in, psw_en, wrong_psw, op_valid;
  logic [BW-1:0] balance, amount;
  logic [1:0]    op_code;
  logic          op_ready, op_done, card_out;
  logic [BW-1:0] updated_balance;
  logic [1:0]    status;

  int checks   = 0;
  int failures = 0;

  logic          chk_on = 1'b0;
  logic          exp_ready = 1'b0, exp_done = 1'b0, exp_cout = 1'b0;
  logic [BW-1:0] exp_ub = '0;
  logic [1:0]    exp_status = 2'b00;
  longint        model_b = 0;

  atm_transaction_ctrl #(
    .balance_width (BW),
    .max_tries     (3),
    .timeout_cycles(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .card_in        (card_in),
    .psw_en         (psw_en),
    .wrong_psw      (wrong_psw),
    .balance        (balance),
    .op_valid       (op_valid),
    .op_code        (op_code),
    .amount         (amount),
    .op_ready       (op_ready),
    .op_done        (op_done),
    .updated_balance(updated_balance),
    .status         (status),
    .card_out       (card_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the current expectation
  always @(negedge clk) begin
    if (chk_on) begin
      chk("op_ready", 32'(op_ready), 32'(exp_ready));
      chk("op_done", 32'(op_done), 32'(exp_done));
      chk("card_out", 32'(card_out), 32'(exp_cout));
      chk("updated_balance", 32'(updated_balance), 32'(exp_ub));
      chk("status", 32'(status), 32'(exp_status));
    end
  end

  // Advance one clock; the flags given are what must be visible after it
  task automatic tick(input logic r, input logic d, input logic c);
    @(posedge clk);
    #1;
    exp_ready = r;
    exp_done  = d;
    exp_cout  = c;
  endtask

  // Balance model: what one operation must return given the current balance
  task automatic model_op(input logic [1:0] code, input longint amt);
    logic [1:0] st;
    st = 2'b00;
    case (code)
      2'b01: if (amt > model_b) st = 2'b01; else model_b = model_b - amt;
      2'b10: if (model_b + amt > BAL_MAX) st = 2'b10; else model_b = model_b + amt;
      default: ;
    endcase
    exp_ub     = BW'(model_b);
    exp_status = st;
  endtask

  // Issue one operation from a READY cycle; returns in READY (or REMOVE on exit)
  task automatic do_op(input logic [1:0] code, input logic [BW-1:0] amt);
    op_valid = 1'b1;
    op_code  = code;
    amount   = amt;
    tick(0, 0, 0);          // EXEC
    op_valid = 1'b0;
    amount   = '0;
    tick(0, 1, 0);          // DONE: result visible with op_done
    model_op(code, longint'(amt));
    if (code == 2'b11) begin
      tick(0, 0, 1);        // eject pulse
      tick(0, 0, 0);        // waiting for removal
    end else begin
      tick(1, 0, 0);        // ready again straight away
    end
  endtask

  // Authenticate from IDLE with the given balance
  task automatic insert_and_auth(input logic [BW-1:0] bal);
    card_in = 1'b1;
    tick(0, 0, 0);          // AUTH
    psw_en  = 1'b1;
    balance = bal;
    tick(1, 0, 0);          // READY
    psw_en  = 1'b0;
    model_b = longint'(bal);
  endtask

  initial begin
    rst = 1'b1; card_in = 1'b0; psw_en = 1'b0; wrong_psw = 1'b0;
    op_valid = 1'b0; op_code = 2'b00; balance = '0; amount = '0;
    tick(0, 0, 0);
    chk_on = 1'b1;
    tick(0, 0, 0);
    rst = 1'b0;
    tick(0, 0, 0);

    // Authenticate with 1000, withdraw 300, deposit 50, overdraw, inquiry
    insert_and_auth(BW'(1000));
    do_op(2'b01, BW'(300));
    chk("withdraw_300", 32'(updated_balance), 32'd700);
    do_op(2'b10, BW'(50));
    chk("deposit_50", 32'(updated_balance), 32'd750);
    do_op(2'b01, BW'(800));
    chk("overdraw_bal", 32'(updated_balance), 32'd750);
    chk("overdraw_status", 32'(status), 32'd1);
    do_op(2'b00, BW'(5));
    chk("inquiry_status", 32'(status), 32'd0);

    // Exit, then card held in slot: no re-authentication while still present
    do_op(2'b11, '0);
    chk("exit_bal", 32'(updated_balance), 32'd750);
    psw_en = 1'b1; op_valid = 1'b1; balance = BW'(9);
    repeat (4) tick(0, 0, 0);
    psw_en = 1'b0; op_valid = 1'b0;
    card_in = 1'b0;
    tick(0, 0, 0);          // IDLE

    // Balance at maximum: deposit overflow, deposit 0, withdraw 0
    insert_and_auth(BW'(BAL_MAX));
    do_op(2'b10, BW'(1));
    chk("ovf_status", 32'(status), 32'd2);
    chk("ovf_bal", 32'(updated_balance), 32'(BAL_MAX));
    do_op(2'b10, BW'(0));
    chk("dep0_status", 32'(status), 32'd0);
    do_op(2'b01, BW'(0));
    chk("wd0_bal", 32'(updated_balance), 32'(BAL_MAX));

    // Inactivity: 8 READY cycles then eject, status untouched
    repeat (7) tick(1, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    chk("timeout_status", 32'(status), 32'd0);
    card_in = 1'b0;
    tick(0, 0, 0);          // IDLE
    card_in = 1'b1;
    tick(0, 0, 0);          // AUTH
    card_in = 1'b0;
    tick(0, 0, 0);          // removal in AUTH: IDLE without eject

    // Three wrong passwords lock the card out
    card_in = 1'b1;
    tick(0, 0, 0);          // AUTH
    for (int i = 0; i < 3; i++) begin
      wrong_psw = 1'b1;
      if (i < 2) begin
        tick(0, 0, 0);
        wrong_psw = 1'b0;
        tick(0, 0, 0);
      end else begin
        tick(0, 0, 1);
        exp_status = 2'b11;
        wrong_psw  = 1'b0;
      end
    end
    tick(0, 0, 0);          // REMOVE
    chk("lock_status", 32'(status), 32'd3);
    card_in = 1'b0;
    tick(0, 0, 0);

    // psw_en wins over a simultaneous wrong_psw; wrong_psw ignored in READY
    card_in = 1'b1;
    tick(0, 0, 0);
    psw_en = 1'b1; wrong_psw = 1'b1; balance = BW'(500);
    tick(1, 0, 0);
    model_b = 500;
    psw_en = 1'b0;
    tick(1, 0, 0);
    wrong_psw = 1'b0;
    do_op(2'b00, '0);
    chk("reauth_bal", 32'(updated_balance), 32'd500);

    // Reset while a withdraw is in EXEC: no op_done, everything cleared
    op_valid = 1'b1; op_code = 2'b01; amount = BW'(100);
    tick(0, 0, 0);          // EXEC
    op_valid = 1'b0;
    rst = 1'b1;
    tick(0, 0, 0);
    exp_ub = '0; exp_status = 2'b00; model_b = 0;
    chk("rst_bal", 32'(updated_balance), 32'd0);
    rst = 1'b0;
    insert_and_auth(BW'(42));
    do_op(2'b00, '0);
    chk("post_rst_bal", 32'(updated_balance), 32'd42);

    card_in = 1'b0;
    tick(0, 0, 0);
    @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
